seat_plan_ctrl: RTL and testbench
=================================

# seat_plan_ctrl

Sequencing controller for the exam question-order table. On `start` it fills an S-row (student) by Q-column (slot) table, one cell per clock, column-major. Each cell gets a question id 1..Q chosen by a least-used rule that avoids repeats within a row and, optionally, equal ids for adjacent students. Once filled, the table is served to the display/readout side through a single-cycle read port.

## Interface
- `S`, 5, number of students (rows), ≥2
- `Q`, 3, number of questions = number of columns, 2..7
- `ID_W`, 3, question id width; 0 means empty cell
- `clk` in 1, single clock, rising edge
- `rst_n` in 1, reset is asynchronous and active-low
- `start` in 1, begin a new fill (pulse)
- `busy` out 1, high during FILL
- `done` out 1, high in DONE (table valid)
- `rd_en` in 1, read request
- `rd_row` in $clog2(S), 0-based student index
- `rd_col` in $clog2(Q), 0-based column index
- `rd_data` out ID_W, cell contents, valid the cycle after `rd_en`
- `rd_err` out 1, one-cycle flag aligned with `rd_data`: read not in DONE or address out of range

## Operation
- FSM: IDLE → FILL on `start`; FILL → DONE after last cell; DONE → FILL on `start`; `start` in FILL is ignored.
- Entering FILL: table cleared to 0, row=0, col=0, per-column counts cleared.
- Column 0, row r: id = (r mod Q)+1.
- Column c≥1, row r:
  - E = ids 1..Q not already in row r columns 0..c-1.
  - Adjacency exclusion: if r≥1 and E minus {cell(r-1,c)} is non-empty, use that reduced set.
  - Pick the id in E with the minimum count so far in column c; ties go to the lowest id.
- Count[c][id] increments on each write; width $clog2(S+1), no saturation needed.
- Cell advance: row++ each cycle; at row S-1, row=0 and col++. The write to (S-1,Q-1) ends FILL.
- Reads are accepted in any state.
  - Out of DONE, or `rd_row`≥S or `rd_col`≥Q: `rd_data`=0, `rd_err`=1.
  - Otherwise: `rd_data` = the cell, `rd_err`=0.

## Timing
- Reset values: `busy`=0, `done`=0, `rd_data`=0, `rd_err`=0; table, counts and indices 0; state IDLE.
- `start` sampled at cycle t: `busy`=1 from t+1; first cell written at the t+1 edge.
- FILL lasts exactly S·Q cycles. `busy`→0 and `done`→1 in the same cycle; `done` holds until the next `start`.
- Read latency is 1 cycle; back-to-back reads every cycle are supported.
- `start` in DONE: `done` drops the next cycle and the table clears.
- `rst_n` asserted mid-FILL: immediate return to IDLE with everything cleared. No partial table is retained.

## Configuration
- `SEAT_PLAN_ADJ_AVOID_EN`
  - Defined: adjacency exclusion as above.
  - Undefined: the exclusion step is removed; E is used directly with least-count selection. Column 0 rule is unchanged.

## Structure
- Package `seat_plan_pkg`:
  - state enum {IDLE, FILL, DONE}
  - default `ID_W`
  - `EMPTY_ID`=0 constant
- Sub-module `seat_pick`: purely combinational selector.
  - Inputs: row-used mask, above id, column count vector.
  - Output: chosen id.
  - Instanced once in `seat_plan_ctrl`, which owns the FSM, table storage, counts and read port.

## Test plan
- Reset then idle read (0,0): `rd_err`=1, `rd_data`=0; `busy`/`done` stay 0.
- `start` with S=5, Q=3, macro defined: `busy` high 15 cycles, then `done`. Rows read back (1,2,3), (2,1,3), (3,2,1), (1,3,2), (2,1,3).
- Same fill with macro undefined: rows (1,2,3), (2,1,3), (3,1,2), (1,3,2), (2,3,1).
- Read `rd_row`=5 in DONE: `rd_err`=1. `start` pulsed during FILL at cycle 7: ignored, total fill still 15 cycles.
- `rst_n` low at fill cycle 8, release, then `start`: table matches the second scenario exactly, with no stale cells.
- Restart from DONE: `done` low next cycle, reads return `rd_err`=1 until the new `done`; final table identical to the first fill.

Source files
------------

// File: rtl/seat_plan_pkg.sv
// Shared types and constants for the exam seat-plan sequencer.
// Optional adjacency avoidance is enabled by defining SEAT_PLAN_ADJ_AVOID_EN.
package seat_plan_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_ID_W = 3;

   // Question ids start at 1; 0 marks a cell that has not been written yet.
   localparam int EMPTY_ID = 0;

endpackage

// File: rtl/seat_pick.sv
// Combinational least-used question picker for one table cell.
// With SEAT_PLAN_ADJ_AVOID_EN defined, the id held by the student above is avoided when possible.
module seat_pick
   import seat_plan_pkg::*;
#(
   parameter int Q     = 3,
   parameter int ID_W  = DEFAULT_ID_W,
   parameter int CNT_W = 3
) (
   input  logic [Q-1:0]       used,
   input  logic [ID_W-1:0]    above,
   input  logic [Q*CNT_W-1:0] counts,
   output logic [ID_W-1:0]    pick
);

   logic [Q-1:0]     cand;
   logic [CNT_W-1:0] best;
   logic             found;

`ifdef SEAT_PLAN_ADJ_AVOID_EN
   logic [Q-1:0] reduced;

   always_comb begin
      // NOTE: every variable written here gets a default first, so no latch is inferred.
      cand    = ~used;
      reduced = cand;
      for (int i = 0; i < Q; i++) begin
         if (above == ID_W'(i + 1)) reduced[i] = 1'b0;
      end
      // Dropping the neighbour's id must never leave the row without a candidate.
      if (reduced != '0) cand = reduced;
   end
`else
   logic unused_above;
   assign unused_above = ^above;

   always_comb begin
      cand = ~used;
   end
`endif

   // Strict less-than keeps the lowest id when counts tie.
   always_comb begin
      best  = '0;
      found = 1'b0;
      pick  = ID_W'(EMPTY_ID);
      for (int i = 0; i < Q; i++) begin
         if (cand[i] && (!found || counts[i*CNT_W +: CNT_W] < best)) begin
            found = 1'b1;
            best  = counts[i*CNT_W +: CNT_W];
            pick  = ID_W'(i + 1);
         end
      end
   end

endmodule

// File: rtl/seat_plan_ctrl.sv
// Fills an S x Q question-order table column-major, one cell per clock, and serves it through a 1-cycle read port.
// Define SEAT_PLAN_ADJ_AVOID_EN to make adjacent students avoid sharing a question id.
module seat_plan_ctrl
   import seat_plan_pkg::*;
#(
   parameter int S    = 5,
   parameter int Q    = 3,
   parameter int ID_W = DEFAULT_ID_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   input  logic                 rd_en,
   input  logic [$clog2(S)-1:0] rd_row,
   input  logic [$clog2(Q)-1:0] rd_col,
   output logic [ID_W-1:0]      rd_data,
   output logic                 rd_err
);

   localparam int ROW_W = $clog2(S);
   localparam int COL_W = $clog2(Q);
   localparam int CNT_W = $clog2(S + 1);

   state_t state, state_nx;

   logic [ROW_W-1:0] row;
   logic [COL_W-1:0] col;
   logic [ID_W-1:0]  cells [S][Q];
   logic [CNT_W-1:0] cnt   [Q][Q];

   logic             begin_fill;
   logic             last_cell;
   logic             rd_ok;
   logic [Q-1:0]     used;
   logic [ID_W-1:0]  above;
   logic [ID_W-1:0]  col0_id;
   logic [ID_W-1:0]  sel_id;
   logic [ID_W-1:0]  wr_id;
   logic [Q*CNT_W-1:0] col_cnt;

   assign begin_fill = start && (state != FILL);
   assign last_cell  = (row == ROW_W'(S - 1)) && (col == COL_W'(Q - 1));

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start)     state_nx = FILL;
         FILL:    if (last_cell) state_nx = DONE;
         DONE:    if (start)     state_nx = FILL;
         default:                state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == FILL);
      done = (state == DONE);
   end

   // ---------------- cell selection ----------------
   always_comb begin
      used = '0;
      for (int k = 0; k < Q; k++) begin
         for (int i = 0; i < Q; i++) begin
            if (COL_W'(k) < col && cells[row][k] == ID_W'(i + 1)) used[i] = 1'b1;
         end
      end
   end

   assign above   = (row == '0) ? ID_W'(EMPTY_ID) : cells[row - ROW_W'(1)][col];
   assign col0_id = ID_W'((int'(row) % Q) + 1);

   always_comb begin
      col_cnt = '0;
      for (int i = 0; i < Q; i++) begin
         col_cnt[i*CNT_W +: CNT_W] = cnt[col][i];
      end
   end

   seat_pick #(
      .Q     (Q),
      .ID_W  (ID_W),
      .CNT_W (CNT_W)
   ) u_pick (
      .used   (used),
      .above  (above),
      .counts (col_cnt),
      .pick   (sel_id)
   );

   // Column 0 is a fixed rotation; later columns use the least-used picker.
   assign wr_id = (col == '0) ? col0_id : sel_id;

   // ---------------- table, counts and walk indices ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row <= '0;
         col <= '0;
         // NOTE: the table is a small register array, reset explicitly so no partial plan survives a reset.
         for (int r = 0; r < S; r++)
            for (int c = 0; c < Q; c++)
               cells[r][c] <= ID_W'(EMPTY_ID);
         for (int c = 0; c < Q; c++)
            for (int i = 0; i < Q; i++)
               cnt[c][i] <= '0;
      end else if (begin_fill) begin
         row <= '0;
         col <= '0;
         for (int r = 0; r < S; r++)
            for (int c = 0; c < Q; c++)
               cells[r][c] <= ID_W'(EMPTY_ID);
         for (int c = 0; c < Q; c++)
            for (int i = 0; i < Q; i++)
               cnt[c][i] <= '0;
      end else if (state == FILL) begin
         cells[row][col] <= wr_id;
         for (int i = 0; i < Q; i++) begin
            if (wr_id == ID_W'(i + 1)) cnt[col][i] <= cnt[col][i] + 1'b1;
         end
         if (last_cell) begin
            row <= '0;
            col <= '0;
         end else if (row == ROW_W'(S - 1)) begin
            row <= '0;
            col <= col + 1'b1;
         end else begin
            row <= row + 1'b1;
         end
      end
   end

   // ---------------- read port ----------------
   assign rd_ok = (state == DONE) && (int'(rd_row) < S) && (int'(rd_col) < Q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= '0;
         rd_err  <= 1'b0;
      end else if (rd_en) begin
         if (rd_ok) begin
            rd_data <= cells[rd_row][rd_col];
            rd_err  <= 1'b0;
         end else begin
            rd_data <= '0;
            rd_err  <= 1'b1;
         end
      end else begin
         rd_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_seat_plan_ctrl.sv
// Self-checking bench for seat_plan_ctrl: directed scenarios plus randomized reads/resets against a table model.
module tb_seat_plan_ctrl;

   localparam int S     = 5;
   localparam int Q     = 3;
   localparam int ID_W  = 3;
   localparam int ROW_W = $clog2(S);
   localparam int COL_W = $clog2(Q);

   logic             clk    = 1'b0;
   logic             rst_n  = 1'b0;
   logic             start  = 1'b0;
   logic             rd_en  = 1'b0;
   logic [ROW_W-1:0] rd_row = '0;
   logic [COL_W-1:0] rd_col = '0;
   logic             busy;
   logic             done;
   logic [ID_W-1:0]  rd_data;
   logic             rd_err;

   int n_cmp = 0;
   int n_bad = 0;

   int model_tab [S][Q];
   int plan_tab  [S][Q];

   seat_plan_ctrl #(.S(S), .Q(Q), .ID_W(ID_W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .busy    (busy),
      .done    (done),
      .rd_en   (rd_en),
      .rd_row  (rd_row),
      .rd_col  (rd_col),
      .rd_data (rd_data),
      .rd_err  (rd_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Inputs are driven and outputs sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Counts cycles with busy high; optionally pulses start at a given fill cycle.
   task automatic fill_wait(input int inject_at, output int cycles);
      cycles = 0;
      while (busy === 1'b1 && cycles < 100) begin
         start = (cycles == inject_at);
         tick();
         cycles++;
      end
      start = 1'b0;
   endtask

   // Reference table computed straight from the question-assignment rules.
   task automatic build_model();
      int cnt [8];
      bit cand [8];
      int id, best, a;
      bit any;
      for (int c = 0; c < Q; c++) begin
         for (int v = 0; v < 8; v++) cnt[v] = 0;
         for (int r = 0; r < S; r++) begin
            if (c == 0) begin
               id = (r % Q) + 1;
            end else begin
               for (int v = 1; v <= Q; v++) begin
                  cand[v] = 1'b1;
                  for (int k = 0; k < c; k++) if (model_tab[r][k] == v) cand[v] = 1'b0;
               end
`ifdef SEAT_PLAN_ADJ_AVOID_EN
               if (r >= 1) begin
                  a   = model_tab[r-1][c];
                  any = 1'b0;
                  for (int v = 1; v <= Q; v++) if (cand[v] && v != a) any = 1'b1;
                  if (any) cand[a] = 1'b0;
               end
`endif
               best = 0;
               for (int v = 1; v <= Q; v++)
                  if (cand[v] && (best == 0 || cnt[v] < cnt[best])) best = v;
               id = best;
            end
            model_tab[r][c] = id;
            cnt[id]++;
         end
      end
   endtask

   // Reads the whole table back-to-back, one address per cycle, against the expected plan.
   task automatic read_table_b2b(input string tag);
      int er, ec;
      for (int k = 0; k <= S*Q; k++) begin
         if (k > 0) begin
            er = (k - 1) / Q;
            ec = (k - 1) % Q;
            n_cmp++;
            if (rd_err !== 1'b0 || rd_data !== ID_W'(plan_tab[er][ec])) begin
               n_bad++;
               $display("FAIL %s cell(%0d,%0d): got data=%0d err=%0b, expected data=%0d err=0",
                        tag, er, ec, rd_data, rd_err, plan_tab[er][ec]);
            end
         end
         if (k < S*Q) begin
            rd_en  = 1'b1;
            rd_row = ROW_W'(k / Q);
            rd_col = COL_W'(k % Q);
            tick();
         end else begin
            rd_en = 1'b0;
         end
      end
   endtask

   // Pipelined random reads over the full address space, including out-of-range addresses.
   task automatic rand_reads(input int n, input bit in_done, input string tag);
      int pr, pc;
      bit exp_err;
      logic [ID_W-1:0] exp_data;
      pr = 0;
      pc = 0;
      for (int k = 0; k <= n; k++) begin
         if (k > 0) begin
            exp_err  = !in_done || pr >= S || pc >= Q;
            exp_data = exp_err ? '0 : ID_W'(model_tab[pr][pc]);
            n_cmp++;
            if (rd_err !== exp_err || rd_data !== exp_data) begin
               n_bad++;
               $display("FAIL %s read(%0d,%0d): got data=%0d err=%0b, expected data=%0d err=%0b",
                        tag, pr, pc, rd_data, rd_err, exp_data, exp_err);
            end
         end
         if (k < n) begin
            pr     = $urandom_range(0, (1 << ROW_W) - 1);
            pc     = $urandom_range(0, (1 << COL_W) - 1);
            rd_en  = 1'b1;
            rd_row = ROW_W'(pr);
            rd_col = COL_W'(pc);
            tick();
         end else begin
            rd_en = 1'b0;
         end
      end
   endtask

   task automatic single_read(input int r, input int c, input bit exp_err,
                              input int exp_data, input string tag);
      rd_en  = 1'b1;
      rd_row = ROW_W'(r);
      rd_col = COL_W'(c);
      tick();
      rd_en = 1'b0;
      n_cmp++;
      if (rd_err !== exp_err || rd_data !== ID_W'(exp_data)) begin
         n_bad++;
         $display("FAIL %s read(%0d,%0d): got data=%0d err=%0b, expected data=%0d err=%0b",
                  tag, r, c, rd_data, rd_err, exp_data, exp_err);
      end
   endtask

   task automatic check_flags(input bit exp_busy, input bit exp_done, input string tag);
      n_cmp++;
      if (busy !== exp_busy || done !== exp_done) begin
         n_bad++;
         $display("FAIL %s: got busy=%0b done=%0b, expected busy=%0b done=%0b",
                  tag, busy, done, exp_busy, exp_done);
      end
   endtask

   task automatic check_fill_len(input int cycles, input string tag);
      n_cmp++;
      if (cycles != S*Q) begin
         n_bad++;
         $display("FAIL %s: fill lasted %0d cycles, expected %0d", tag, cycles, S*Q);
      end
   endtask

   task automatic test_reset();
      tick();
      tick();
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || rd_data !== '0 || rd_err !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_values: got busy=%0b done=%0b data=%0d err=%0b, expected all 0",
                  busy, done, rd_data, rd_err);
      end
      rst_n = 1'b1;
      tick();
      single_read(0, 0, 1'b1, 0, "idle_read");
      tick();
      check_flags(1'b0, 1'b0, "idle_flags");
   endtask

   task automatic test_fill();
      int cyc;
      pulse_start();
      check_flags(1'b1, 1'b0, "fill_busy_rise");
      fill_wait(-1, cyc);
      check_fill_len(cyc, "fill_length");
      check_flags(1'b0, 1'b1, "fill_done_rise");
      read_table_b2b("fill_table");
      rand_reads(40, 1'b1, "done_rand");
      check_flags(1'b0, 1'b1, "done_hold");
   endtask

   task automatic test_out_of_range();
      single_read(5, 0, 1'b1, 0, "row_oob");
      single_read(0, 3, 1'b1, 0, "col_oob");
      single_read(7, 3, 1'b1, 0, "both_oob");
      single_read(S-1, Q-1, 1'b0, plan_tab[S-1][Q-1], "last_cell");
   endtask

   task automatic test_start_ignored();
      int cyc;
      pulse_start();
      check_flags(1'b1, 1'b0, "restart_done_drop");
      fill_wait(6, cyc);
      check_fill_len(cyc, "ignored_start_length");
      read_table_b2b("ignored_start_table");
   endtask

   task automatic test_reset_mid_fill();
      int cyc;
      pulse_start();
      for (int i = 0; i < 8; i++) tick();
      #2;
      rst_n = 1'b0;
      #1;
      check_flags(1'b0, 1'b0, "async_reset_flags");
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      single_read(0, 0, 1'b1, 0, "post_reset_read");
      pulse_start();
      fill_wait(-1, cyc);
      check_fill_len(cyc, "post_reset_length");
      read_table_b2b("post_reset_table");
   endtask

   task automatic test_restart();
      int  cyc;
      bit  have;
      int  pr, pc;
      pulse_start();
      check_flags(1'b1, 1'b0, "restart_flags");
      cyc  = 0;
      have = 1'b0;
      pr   = 0;
      pc   = 0;
      while (busy === 1'b1 && cyc < 100) begin
         if (have) begin
            n_cmp++;
            if (rd_err !== 1'b1 || rd_data !== '0) begin
               n_bad++;
               $display("FAIL restart_fill_read(%0d,%0d): got data=%0d err=%0b, expected data=0 err=1",
                        pr, pc, rd_data, rd_err);
            end
         end
         pr     = $urandom_range(0, S - 1);
         pc     = $urandom_range(0, Q - 1);
         rd_en  = 1'b1;
         rd_row = ROW_W'(pr);
         rd_col = COL_W'(pc);
         have   = 1'b1;
         tick();
         cyc++;
      end
      rd_en = 1'b0;
      n_cmp++;
      if (rd_err !== 1'b1 || rd_data !== '0) begin
         n_bad++;
         $display("FAIL restart_last_fill_read: got data=%0d err=%0b, expected data=0 err=1",
                  rd_data, rd_err);
      end
      check_fill_len(cyc, "restart_length");
      check_flags(1'b0, 1'b1, "restart_done");
      read_table_b2b("restart_table");
   endtask

   task automatic test_random_resets();
      int cyc, k;
      for (int it = 0; it < 3; it++) begin
         k = $urandom_range(1, S*Q - 1);
         pulse_start();
         for (int i = 0; i < k; i++) tick();
         #2;
         rst_n = 1'b0;
         #1;
         check_flags(1'b0, 1'b0, "rand_reset_flags");
         tick();
         rst_n = 1'b1;
         for (int i = 0; i < int'($urandom_range(0, 3)); i++) tick();
         rand_reads(5, 1'b0, "rand_idle");
         pulse_start();
         fill_wait(-1, cyc);
         check_fill_len(cyc, "rand_fill_length");
         rand_reads(10, 1'b1, "rand_done");
      end
   endtask

   initial begin
`ifdef SEAT_PLAN_ADJ_AVOID_EN
      plan_tab = '{'{1,2,3}, '{2,1,3}, '{3,2,1}, '{1,3,2}, '{2,1,3}};
`else
      plan_tab = '{'{1,2,3}, '{2,1,3}, '{3,1,2}, '{1,3,2}, '{2,3,1}};
`endif
      build_model();

      test_reset();
      test_fill();
      test_out_of_range();
      test_start_ignored();
      test_reset_mid_fill();
      test_restart();
      test_random_resets();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
